pre_if_req_stage: RTL and testbench
===================================

# pre_if_req_stage

Instruction-fetch request stage; sits directly upstream of the IF-to-ID pipeline register. Owns the fetch PC and issues requests on the SRAM-like instruction port. Hands the accepted PC to the IF stage with a valid/allowin handshake. Applies branch and exception redirects, and tells the IF stage when an accepted response must be discarded.

## Interface
- `RESET_PC`, 32'h1c00_0000, first fetch address after reset
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `now_allowin_i`  in  1  IF stage can accept this cycle
- `excep_flush_i`  in  1  exception/ertn redirect
- `excep_pc_i`  in  32  exception redirect target
- `branch_flush_i`  in  1  branch mispredict redirect
- `branch_pc_i`  in  32  branch redirect target
- `inst_addr_ok_i`  in  1  instruction port accepted the request
- `inst_req_o`  out  1  instruction port request
- `inst_addr_o`  out  32  request address, equal to `pc_o`
- `pre_to_now_valid_o`  out  1  PC offered to the IF stage (`line1_pre_to_now_valid_i` there)
- `pc_o`  out  32  offered PC
- `excep_en_o`  out  1  ADEF on the offered PC
- `inst_rdata_ce_we_o`  out  2  2'b10 means discard one response; otherwise 2'b00 (bit0 never driven)

## Operation
- Registers:
  - `pc_r` (32)
  - `state` in {REQ, WAIT_IN, HALT}
  - `rd_pend`, a 1-bit pending-redirect flag
  - `rd_pc` (32)
  - `rd_exc`, pending redirect is an exception
- Redirect selection: `flush = excep_flush_i | branch_flush_i`. Target is `excep_pc_i` when `excep_flush_i` is set, else `branch_pc_i`.
- Misaligned PC (`pc_r[1:0]!=0`) in REQ:
  - `inst_req_o`=0, `pre_to_now_valid_o`=1, `excep_en_o`=1.
  - If `now_allowin_i` and no flush, go to HALT.
- REQ, aligned PC:
  - `inst_req_o`=1, `inst_addr_o`=`pc_r`. The address stays stable until `inst_addr_ok_i`.
  - Handshake in a flush cycle, or with `rd_pend`=1:
    - `pre_to_now_valid_o`=0 and `inst_rdata_ce_we_o`=2'b10.
    - `pc_r` takes the flush target; the live flush wins over `rd_pend`.
    - `rd_pend` is cleared; stay in REQ.
  - Handshake, clean:
    - `pre_to_now_valid_o`=1.
    - If `now_allowin_i`, then `pc_r`+=4 and stay in REQ; else go to WAIT_IN.
  - No handshake, with flush:
    - Latch the target into `rd_pend`/`rd_pc`.
    - Exception overwrites pending branch; branch never overwrites pending exception; later exception overwrites earlier.
    - Address unchanged.
- WAIT_IN:
  - `inst_req_o`=0, `pre_to_now_valid_o`=1, `pc_o`=`pc_r`.
  - Flush: `pre_to_now_valid_o` is forced 0, `inst_rdata_ce_we_o`=2'b10, `pc_r`=target, go to REQ. Flush wins over `now_allowin_i`.
  - `now_allowin_i` without flush: `pc_r`+=4, go to REQ.
- HALT:
  - All outputs idle.
  - Flush loads `pc_r` with the target and goes to REQ; no ce write.
- Cancelling PCs already latched by the IF stage is the IF stage's job, not this block's.
- PC arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- Reset (while `rst_n`=0):
  - `state`=REQ, `pc_r`=`RESET_PC`, `rd_pend`=0.
  - Outputs: `inst_req_o`=0, `pre_to_now_valid_o`=0, `excep_en_o`=0, `inst_rdata_ce_we_o`=2'b00, `pc_o`=`RESET_PC`.
- First request goes out in the first cycle after `rst_n` rises.
- Reset mid-request drops `inst_req_o` immediately and discards pending redirects.
- `pre_to_now_valid_o` and `inst_rdata_ce_we_o` are combinational from state, `inst_addr_ok_i`, `now_allowin_i` and the flush inputs. The IF stage samples them at the same edge.
- Throughput: one PC per cycle when `inst_addr_ok_i` and `now_allowin_i` stay high.
- Redirect latency:
  - From REQ with port idle-accepting: target on `inst_addr_o` the cycle after the flush.
  - Held request: target on the cycle after the stale handshake.

## Test plan
- Reset release, `addr_ok`=1 and `allowin`=1 held for 4 cycles -> `inst_addr_o` = 1c000000, 1c000004, 1c000008, 1c00000c; valid=1 each cycle.
- `addr_ok`=1 with `allowin`=0 for 3 cycles, then `allowin`=1 -> one handshake only; valid held at pc 1c000000 in WAIT_IN; next request is 1c000004.
- `addr_ok`=0 for 2 cycles; branch flush to 1c000100 in cycle 1; `addr_ok` in cycle 3 -> address stays 1c000000 until accepted; that cycle gives valid=0 and ce_we=10; next address 1c000100.
- Branch flush to 0x200 then exception flush to 0x300 while held; a further branch to 0x400 -> after the stale handshake, address 0x300.
- Branch to 1c000102 -> `inst_req_o`=0, valid=1, `excep_en_o`=1; after `allowin`, outputs idle until `excep_flush_i` to 1c008000 restarts fetch there.
- Flush in WAIT_IN with `allowin`=1 in the same cycle -> valid=0, ce_we=10, next address is the target.

Source files
------------

// File: rtl/pre_if_req_stage.sv
// pre_if_req_stage: fetch PC owner, instruction-port requester,
// redirect tracking and stale-response discard signalling.
module pre_if_req_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        now_allowin_i,
  input  logic        excep_flush_i,
  input  logic [31:0] excep_pc_i,
  input  logic        branch_flush_i,
  input  logic [31:0] branch_pc_i,
  input  logic        inst_addr_ok_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  output logic        pre_to_now_valid_o,
  output logic [31:0] pc_o,
  output logic        excep_en_o,
  output logic [1:0]  inst_rdata_ce_we_o
);

  typedef enum logic [1:0] {
    REQ,
    WAIT_IN,
    HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] rd_pc_q, rd_pc_d;
  logic        rd_exc_q, rd_exc_d;

  logic        flush;
  logic [31:0] tgt;
  logic        misal;
  logic        hs;

  assign flush = excep_flush_i | branch_flush_i;
  assign tgt   = excep_flush_i ? excep_pc_i : branch_pc_i;
  assign misal = pc_q[1:0] != 2'b00;
  assign hs    = inst_addr_ok_i;

  // Outputs must read the reset PC while reset is held.
  assign pc_o        = rst_n ? pc_q : RESET_PC;
  assign inst_addr_o = pc_o;

  // Next state, PC, pending redirect and handshake outputs.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    rd_pend_d          = rd_pend_q;
    rd_pc_d            = rd_pc_q;
    rd_exc_d           = rd_exc_q;
    inst_req_o         = 1'b0;
    pre_to_now_valid_o = 1'b0;
    excep_en_o         = 1'b0;
    inst_rdata_ce_we_o = 2'b00;
    if (rst_n) begin
      unique case (state_q)
        REQ: begin
          if (misal) begin
            pre_to_now_valid_o = 1'b1;
            excep_en_o         = 1'b1;
            if (flush) begin
              pc_d = tgt;
            end else if (now_allowin_i) begin
              state_d = HALT;
            end
          end else begin
            inst_req_o = 1'b1;
            if (hs) begin
              if (flush || rd_pend_q) begin
                // Accepted fetch is stale: discard its response.
                inst_rdata_ce_we_o = 2'b10;
                pc_d      = flush ? tgt : rd_pc_q;
                rd_pend_d = 1'b0;
              end else begin
                pre_to_now_valid_o = 1'b1;
                if (now_allowin_i) begin
                  pc_d = pc_q + 32'd4;
                end else begin
                  state_d = WAIT_IN;
                end
              end
            end else if (excep_flush_i) begin
              rd_pend_d = 1'b1;
              rd_pc_d   = excep_pc_i;
              rd_exc_d  = 1'b1;
            end else if (branch_flush_i) begin
              // A branch never displaces a pending exception.
              if (!(rd_pend_q && rd_exc_q)) begin
                rd_pend_d = 1'b1;
                rd_pc_d   = branch_pc_i;
                rd_exc_d  = 1'b0;
              end
            end
          end
        end
        WAIT_IN: begin
          if (flush) begin
            inst_rdata_ce_we_o = 2'b10;
            pc_d    = tgt;
            state_d = REQ;
          end else begin
            pre_to_now_valid_o = 1'b1;
            if (now_allowin_i) begin
              pc_d    = pc_q + 32'd4;
              state_d = REQ;
            end
          end
        end
        HALT: begin
          if (flush) begin
            pc_d    = tgt;
            state_d = REQ;
          end
        end
        default: begin
          state_d = REQ;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      rd_pend_q <= 1'b0;
      rd_pc_q   <= 32'd0;
      rd_exc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rd_pend_q <= rd_pend_d;
      rd_pc_q   <= rd_pc_d;
      rd_exc_q  <= rd_exc_d;
    end
  end

endmodule

// File: tb/tb_pre_if_req_stage.sv
// tb_pre_if_req_stage: cycle-by-cycle directed vectors
// with hand-computed outputs for pre_if_req_stage.
module tb_pre_if_req_stage;

  logic        clk;
  logic        rst_n;
  logic        now_allowin_i;
  logic        excep_flush_i;
  logic [31:0] excep_pc_i;
  logic        branch_flush_i;
  logic [31:0] branch_pc_i;
  logic        inst_addr_ok_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        pre_to_now_valid_o;
  logic [31:0] pc_o;
  logic        excep_en_o;
  logic [1:0]  inst_rdata_ce_we_o;

  int checks;
  int errors;

  pre_if_req_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .now_allowin_i      (now_allowin_i),
    .excep_flush_i      (excep_flush_i),
    .excep_pc_i         (excep_pc_i),
    .branch_flush_i     (branch_flush_i),
    .branch_pc_i        (branch_pc_i),
    .inst_addr_ok_i     (inst_addr_ok_i),
    .inst_req_o         (inst_req_o),
    .inst_addr_o        (inst_addr_o),
    .pre_to_now_valid_o (pre_to_now_valid_o),
    .pc_o               (pc_o),
    .excep_en_o         (excep_en_o),
    .inst_rdata_ce_we_o (inst_rdata_ce_we_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ok;
    logic        al;
    logic        exf;
    logic [31:0] expc;
    logic        brf;
    logic [31:0] brpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic        exc;
    logic [1:0]  ce;
  } vec_t;

  vec_t vecs[64];
  int   nvec;

  function automatic vec_t mk(
    input logic        rst,
    input logic        ok,
    input logic        al,
    input logic        exf,
    input logic [31:0] expc,
    input logic        brf,
    input logic [31:0] brpc,
    input logic        req,
    input logic [31:0] addr,
    input logic        vld,
    input logic        exc,
    input logic [1:0]  ce
  );
    vec_t v;
    v.rst  = rst;
    v.ok   = ok;
    v.al   = al;
    v.exf  = exf;
    v.expc = expc;
    v.brf  = brf;
    v.brpc = brpc;
    v.req  = req;
    v.addr = addr;
    v.vld  = vld;
    v.exc  = exc;
    v.ce   = ce;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs[nvec] = v;
    nvec++;
  endtask

  task automatic chk(
    input string       tag,
    input string       what,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h",
               tag, what, got, exp);
    end
  endtask

  // One cycle: drive after negedge, sample 1ns later.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    rst_n          = v.rst;
    inst_addr_ok_i = v.ok;
    now_allowin_i  = v.al;
    excep_flush_i  = v.exf;
    excep_pc_i     = v.expc;
    branch_flush_i = v.brf;
    branch_pc_i    = v.brpc;
    #1;
    chk(tag, "req", {31'd0, inst_req_o}, {31'd0, v.req});
    chk(tag, "addr", inst_addr_o, v.addr);
    chk(tag, "pc", pc_o, v.addr);
    chk(tag, "valid", {31'd0, pre_to_now_valid_o},
        {31'd0, v.vld});
    chk(tag, "excep", {31'd0, excep_en_o}, {31'd0, v.exc});
    chk(tag, "ce_we", {30'd0, inst_rdata_ce_we_o},
        {30'd0, v.ce});
  endtask

  localparam logic [31:0] B = 32'h1c00_0000;

  initial begin
    checks         = 0;
    errors         = 0;
    nvec           = 0;
    rst_n          = 1'b0;
    inst_addr_ok_i = 1'b0;
    now_allowin_i  = 1'b0;
    excep_flush_i  = 1'b0;
    excep_pc_i     = 32'd0;
    branch_flush_i = 1'b0;
    branch_pc_i    = 32'd0;

    // reset
    add(mk(0,1,1, 0,0, 0,0, 0,B,       0,0,2'b00));
    add(mk(0,1,1, 0,0, 0,0, 0,B,       0,0,2'b00));
    // streaming
    add(mk(1,1,1, 0,0, 0,0, 1,B,       1,0,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 1,B+4,     1,0,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 1,B+8,     1,0,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 1,B+12,    1,0,2'b00));
    // allowin stall -> WAIT_IN
    add(mk(1,1,0, 0,0, 0,0, 1,B+16,    1,0,2'b00));
    add(mk(1,1,0, 0,0, 0,0, 0,B+16,    1,0,2'b00));
    add(mk(1,1,0, 0,0, 0,0, 0,B+16,    1,0,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 0,B+16,    1,0,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 1,B+20,    1,0,2'b00));
    // held request, branch pending
    add(mk(1,0,1, 0,0, 0,0, 1,B+24,    0,0,2'b00));
    add(mk(1,0,1, 0,0, 1,B+32'h100,
           1,B+24, 0,0,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 1,B+24,    0,0,2'b10));
    add(mk(1,1,1, 0,0, 0,0, 1,B+32'h100, 1,0,2'b00));
    // branch, exception, ignored branch while held
    add(mk(1,0,1, 0,0, 1,B+32'h200,
           1,B+32'h104, 0,0,2'b00));
    add(mk(1,0,1, 1,B+32'h300, 0,0,
           1,B+32'h104, 0,0,2'b00));
    add(mk(1,0,1, 0,0, 1,B+32'h400,
           1,B+32'h104, 0,0,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 1,B+32'h104, 0,0,2'b10));
    add(mk(1,1,1, 0,0, 0,0, 1,B+32'h300, 1,0,2'b00));
    // live flush beats a pending one
    add(mk(1,0,1, 1,B+32'h500, 0,0,
           1,B+32'h304, 0,0,2'b00));
    add(mk(1,1,1, 0,0, 1,B+32'h600,
           1,B+32'h304, 0,0,2'b10));
    add(mk(1,1,1, 0,0, 0,0, 1,B+32'h600, 1,0,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 1,B+32'h604, 1,0,2'b00));
    // misaligned target, HALT, exception restart
    add(mk(1,1,1, 0,0, 1,B+32'h102,
           1,B+32'h608, 0,0,2'b10));
    add(mk(1,0,0, 0,0, 0,0, 0,B+32'h102, 1,1,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 0,B+32'h102, 1,1,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 0,B+32'h102, 0,0,2'b00));
    add(mk(1,1,1, 1,B+32'h8000, 0,0,
           0,B+32'h102, 0,0,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 1,B+32'h8000, 1,0,2'b00));
    // flush in WAIT_IN beats allowin
    add(mk(1,1,0, 0,0, 0,0, 1,B+32'h8004, 1,0,2'b00));
    add(mk(1,0,1, 0,0, 1,B+32'h700,
           0,B+32'h8004, 0,0,2'b10));
    add(mk(1,1,1, 0,0, 0,0, 1,B+32'h700, 1,0,2'b00));
    // PC wrap
    add(mk(1,1,1, 0,0, 1,32'hffff_fffc,
           1,B+32'h704, 0,0,2'b10));
    add(mk(1,1,1, 0,0, 0,0, 1,32'hffff_fffc, 1,0,2'b00));
    add(mk(1,1,1, 0,0, 0,0, 1,32'h0000_0000, 1,0,2'b00));
    // reset mid-request
    add(mk(0,0,1, 0,0, 0,0, 0,B,       0,0,2'b00));

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i], $sformatf("row%0d", i));
    end

    // Reset must discard a latched pending redirect.
    step(mk(1,0,1, 0,0, 1,B+32'h900, 1,B, 0,0,2'b00),
         "pend_set");
    step(mk(0,0,1, 0,0, 0,0, 0,B, 0,0,2'b00),
         "pend_rst");
    step(mk(1,1,1, 0,0, 0,0, 1,B, 1,0,2'b00),
         "pend_gone0");
    step(mk(1,1,1, 0,0, 0,0, 1,B+4, 1,0,2'b00),
         "pend_gone1");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
